// File: rtl/ex_fwd_ctrl.sv
// ----------------------------------------------------------------------------
// ex_fwd_ctrl
//   Execute-stage forwarding and stall control. It has two jobs:
//   - Select the operand source (register file, EX/MEM, MEM/WB or retire) for
//     the A and B sides of the instruction in EX.
//   - Stall the front of the pipeline on a load-use hazard, and while the
//     multi-cycle ALU is busy.
//   The Multi_Alu sequencer runs IDLE -> MBUSY -> MDONE -> IDLE. It holds
//   stall for MULTI_LAT-1 cycles per multi op.
//
// Parameters
//   MULTI_LAT  cycles a Multi_Alu op occupies EX (1..15)
//   RAW        register address width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid              ID/EX holds a real instruction
//   ex_rs1/ex_rs2         EX source addresses
//   ex_use1/ex_use2       source is actually read
//   ex_multi              EX instruction uses the Multi_Alu
//   m_rd/m_we/m_load      EX/MEM destination, write enable, load flag
//   w_rd/w_we             MEM/WB destination, write enable
//   r_rd/r_we             retire destination, write enable
//   sel_fw_a/sel_fw_b     0=reg 1=EX/MEM 2=MEM/WB 3=retire
//   stall                 freeze PC, IF/ID, ID/EX
//   bubble_m              insert a NOP into EX/MEM
//   multi_busy            sequencer not IDLE
//   stall_cnt             stall-cycle counter (only with EX_STALL_CNT_EN)
//
// Build option: define EX_STALL_CNT_EN to add the stall_cnt output.
// ----------------------------------------------------------------------------
module ex_fwd_ctrl #(
    parameter int MULTI_LAT = 4,
    parameter int RAW       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ex_valid,
    input  logic [RAW-1:0] ex_rs1,
    input  logic [RAW-1:0] ex_rs2,
    input  logic           ex_use1,
    input  logic           ex_use2,
    input  logic           ex_multi,
    input  logic [RAW-1:0] m_rd,
    input  logic           m_we,
    input  logic           m_load,
    input  logic [RAW-1:0] w_rd,
    input  logic           w_we,
    input  logic [RAW-1:0] r_rd,
    input  logic           r_we,
    output logic [1:0]     sel_fw_a,
    output logic [1:0]     sel_fw_b,
    output logic           stall,
    output logic           bubble_m,
    output logic           multi_busy
`ifdef EX_STALL_CNT_EN
    , output logic [31:0]  stall_cnt
`endif
);

    localparam bit         MULTI_EN = (MULTI_LAT > 1);
    localparam logic [3:0] CNT_LOAD = MULTI_EN ? 4'(MULTI_LAT - 2) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MBUSY = 2'd1,
        MDONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       capture;
    logic [1:0] sel_hold_a, sel_hold_b;
    logic [1:0] sel_comb_a, sel_comb_b;
    logic       m_hit_a, m_hit_b, w_hit_a, w_hit_b, r_hit_a, r_hit_b;
    logic       load_use;

    // A stage forwards to a source only when it really writes a non-zero
    // register that the valid EX instruction really reads.
    function automatic logic hit(input logic we, input logic [RAW-1:0] rd,
                                 input logic [RAW-1:0] rs, input logic rd_use,
                                 input logic valid);
        return we && (rd != '0) && (rd == rs) && rd_use && valid;
    endfunction

    // A load in EX/MEM has no data yet, so it never forwards from Fw1.
    function automatic logic [1:0] pick(input logic m, input logic w,
                                        input logic r, input logic load);
        if (m && !load) return 2'd1;
        else if (w)     return 2'd2;
        else if (r)     return 2'd3;
        else            return 2'd0;
    endfunction

    always_comb begin
        m_hit_a    = hit(m_we, m_rd, ex_rs1, ex_use1, ex_valid);
        m_hit_b    = hit(m_we, m_rd, ex_rs2, ex_use2, ex_valid);
        w_hit_a    = hit(w_we, w_rd, ex_rs1, ex_use1, ex_valid);
        w_hit_b    = hit(w_we, w_rd, ex_rs2, ex_use2, ex_valid);
        r_hit_a    = hit(r_we, r_rd, ex_rs1, ex_use1, ex_valid);
        r_hit_b    = hit(r_we, r_rd, ex_rs2, ex_use2, ex_valid);
        load_use   = m_load && (m_hit_a || m_hit_b);
        sel_comb_a = pick(m_hit_a, w_hit_a, r_hit_a, m_load);
        sel_comb_b = pick(m_hit_b, w_hit_b, r_hit_b, m_load);
    end

    // Sequencer next-state. A load-use hazard holds the FSM in IDLE, so the
    // stall for the load is served before the multi op starts.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (MULTI_EN && ex_valid && ex_multi && !load_use) begin
                    state_n = MBUSY;
                    cnt_n   = CNT_LOAD;
                    capture = 1'b1;
                end
            end
            MBUSY: begin
                if (cnt == '0) state_n = MDONE;
                else           cnt_n   = cnt - 4'd1;
            end
            MDONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel_hold_a <= '0;
            sel_hold_b <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                sel_hold_a <= sel_comb_a;
                sel_hold_b <= sel_comb_b;
            end
        end
    end

    // While the multi op is busy, older stages drain. The selects captured
    // at issue are held, so the operands stay stable until the op finishes.
    always_comb begin
        sel_fw_a   = (state == MBUSY) ? sel_hold_a : sel_comb_a;
        sel_fw_b   = (state == MBUSY) ? sel_hold_b : sel_comb_b;
        stall      = (load_use && rst_n) || (state == MBUSY);
        bubble_m   = stall;
        multi_busy = (state != IDLE);
    end

`ifdef EX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     stall_cnt <= '0;
        else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_fwd_ctrl
//   Directed scoreboard bench for ex_fwd_ctrl.
//   - u0 uses MULTI_LAT=4.
//   - u1 uses MULTI_LAT=1 and shares the same inputs.
//   Stimulus is applied 1 time unit after each rising edge, and the expected
//   outputs for that cycle are queued at the same time. A monitor on the
//   falling edge pops each entry and compares it against the DUT outputs.
//   Define EX_STALL_CNT_EN to also track stall_cnt.
// ----------------------------------------------------------------------------
module tb_ex_fwd_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       use1;
        logic       use2;
        logic       multi;
        logic [3:0] m_rd;
        logic       m_we;
        logic       m_load;
        logic [3:0] w_rd;
        logic       w_we;
        logic [3:0] r_rd;
        logic       r_we;
    } stim_t;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       bz;
        logic       c1;
    } exp_t;

    stim_t cur = '0;
    stim_t nx  = '0;

    logic [1:0] sel_a0, sel_b0, sel_a1, sel_b1;
    logic       stall0, bub0, busy0, stall1, bub1, busy1;
`ifdef EX_STALL_CNT_EN
    logic [31:0] scnt0, scnt1;
    int unsigned exp_cnt = 0;
`endif

    ex_fwd_ctrl #(.MULTI_LAT(4), .RAW(4)) u0 (
        .clk(clk), .rst_n(rst_n), .ex_valid(cur.valid),
        .ex_rs1(cur.rs1), .ex_rs2(cur.rs2), .ex_use1(cur.use1), .ex_use2(cur.use2),
        .ex_multi(cur.multi), .m_rd(cur.m_rd), .m_we(cur.m_we), .m_load(cur.m_load),
        .w_rd(cur.w_rd), .w_we(cur.w_we), .r_rd(cur.r_rd), .r_we(cur.r_we),
        .sel_fw_a(sel_a0), .sel_fw_b(sel_b0), .stall(stall0), .bubble_m(bub0),
        .multi_busy(busy0)
`ifdef EX_STALL_CNT_EN
        , .stall_cnt(scnt0)
`endif
    );

    ex_fwd_ctrl #(.MULTI_LAT(1), .RAW(4)) u1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(cur.valid),
        .ex_rs1(cur.rs1), .ex_rs2(cur.rs2), .ex_use1(cur.use1), .ex_use2(cur.use2),
        .ex_multi(cur.multi), .m_rd(cur.m_rd), .m_we(cur.m_we), .m_load(cur.m_load),
        .w_rd(cur.w_rd), .w_we(cur.w_we), .r_rd(cur.r_rd), .r_we(cur.r_we),
        .sel_fw_a(sel_a1), .sel_fw_b(sel_b1), .stall(stall1), .bubble_m(bub1),
        .multi_busy(busy1)
`ifdef EX_STALL_CNT_EN
        , .stall_cnt(scnt1)
`endif
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t        exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One pipeline cycle: apply the staged inputs and queue what must be seen.
    task automatic cyc(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                       input logic es, input logic ebz, input logic c1 = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        cur  = nx;
        e.a  = ea;
        e.b  = eb;
        e.st = es;
        e.bz = ebz;
        e.c1 = c1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic clr();
        nx = '0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "/sel_a"}, 32'(sel_a0), 32'(e.a));
            check({t, "/sel_b"}, 32'(sel_b0), 32'(e.b));
            check({t, "/stall"}, 32'(stall0), 32'(e.st));
            check({t, "/bubble"}, 32'(bub0), 32'(e.st));
            check({t, "/busy"}, 32'(busy0), 32'(e.bz));
`ifdef EX_STALL_CNT_EN
            check({t, "/stall_cnt"}, scnt0, exp_cnt);
            if (e.st) exp_cnt++;
`endif
            if (e.c1) begin
                check({t, "/lat1_stall"}, 32'(stall1), 32'd0);
                check({t, "/lat1_busy"}, 32'(busy1), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("in_reset/stall", 32'(stall0), 32'd0);
        check("in_reset/busy", 32'(busy0), 32'd0);
        check("in_reset/sel_a", 32'(sel_a0), 32'd0);
        check("in_reset/sel_b", 32'(sel_b0), 32'd0);
        #5;
        rst_n = 1'b1;

        clr(); cyc("idle", 0, 0, 0, 0);

        // forwarding priority
        clr(); nx.valid = 1; nx.rs1 = 5; nx.use1 = 1;
        nx.m_rd = 5; nx.m_we = 1; nx.w_rd = 5; nx.w_we = 1;
        cyc("fw1_prio", 1, 0, 0, 0);
        nx.m_we = 0;                              cyc("fw2", 2, 0, 0, 0);
        nx.w_we = 0; nx.r_rd = 5; nx.r_we = 1;    cyc("fw3", 3, 0, 0, 0);
        nx.valid = 0;                             cyc("no_valid", 0, 0, 0, 0);
        clr(); nx.valid = 1; nx.rs2 = 0; nx.use2 = 1; nx.r_rd = 0; nx.r_we = 1;
        cyc("x0_b", 0, 0, 0, 0);
        clr(); nx.valid = 1; nx.rs2 = 6; nx.use2 = 0; nx.m_rd = 6; nx.m_we = 1;
        cyc("use2_off", 0, 0, 0, 0);

        // load-use hazard, then MEM/WB forwarding
        clr(); nx.valid = 1; nx.rs2 = 7; nx.use2 = 1;
        nx.m_rd = 7; nx.m_we = 1; nx.m_load = 1;
        cyc("lu_stall", 0, 0, 1, 0);
        nx.m_we = 0; nx.m_load = 0; nx.m_rd = 0; nx.w_rd = 7; nx.w_we = 1;
        cyc("lu_after", 0, 2, 0, 0);
        clr(); nx.valid = 1; nx.rs1 = 7; nx.use1 = 1;
        nx.m_rd = 8; nx.m_we = 1; nx.m_load = 1;
        cyc("load_nomatch", 0, 0, 0, 0);

        // single multi op: select held at issue value during MBUSY
        clr(); nx.valid = 1; nx.multi = 1; nx.rs1 = 3; nx.use1 = 1;
        nx.m_rd = 3; nx.m_we = 1;
        cyc("mul_issue", 1, 0, 0, 0);
        nx.m_we = 0; nx.w_rd = 3; nx.w_we = 1;
        cyc("mbusy1", 1, 0, 1, 1);
        cyc("mbusy2", 1, 0, 1, 1);
        cyc("mbusy3", 1, 0, 1, 1);
        cyc("mdone", 2, 0, 0, 1);
        clr(); cyc("mul_idle", 0, 0, 0, 0);

        // load-use coinciding with a multi op: load stall first, then FSM
        clr(); nx.valid = 1; nx.multi = 1; nx.rs1 = 9; nx.use1 = 1;
        nx.m_rd = 9; nx.m_we = 1; nx.m_load = 1;
        cyc("lu_mul", 0, 0, 1, 0);
        nx.m_we = 0; nx.m_load = 0; nx.m_rd = 0; nx.w_rd = 9; nx.w_we = 1;
        cyc("lu_mul_go", 2, 0, 0, 0);
        nx.w_we = 0;
        cyc("lm_busy1", 2, 0, 1, 1);
        cyc("lm_busy2", 2, 0, 1, 1);
        cyc("lm_busy3", 2, 0, 1, 1);
        cyc("lm_done", 0, 0, 0, 1);
        clr(); cyc("lm_idle", 0, 0, 0, 0);

        // back-to-back multi ops; also checks MULTI_LAT=1 never stalls
        clr(); nx.valid = 1; nx.multi = 1;
        cyc("b2b_issue", 0, 0, 0, 0, 1);
        cyc("b2b_busy1", 0, 0, 1, 1, 1);
        cyc("b2b_busy2", 0, 0, 1, 1, 1);
        cyc("b2b_busy3", 0, 0, 1, 1, 1);
        cyc("b2b_done", 0, 0, 0, 1, 1);
        cyc("b2b_reissue", 0, 0, 0, 0, 1);
        cyc("b2b_rbusy1", 0, 0, 1, 1, 1);

        // asynchronous reset in the 2nd MBUSY cycle
        @(posedge clk);
        #1;
        rst_n = 1'b0;
`ifdef EX_STALL_CNT_EN
        exp_cnt = 0;
`endif
        #1;
        check("arst/stall", 32'(stall0), 32'd0);
        check("arst/bubble", 32'(bub0), 32'd0);
        check("arst/busy", 32'(busy0), 32'd0);
`ifdef EX_STALL_CNT_EN
        check("arst/stall_cnt", scnt0, 32'd0);
`endif
        clr();
        cur = nx;
        #2;
        rst_n = 1'b1;
        cyc("post_rst", 0, 0, 0, 0);
        cyc("post_rst2", 0, 0, 0, 0, 1);

        @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
